if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter and the instruction memory, and drives the IF side of the IF/ID pipeline register with `if_pc_plus_4` and `if_instruction`. It is the producer that the IF/ID register samples every cycle. A small IDLE/RUN/HALT controller lets the debug unit load a program, start execution and observe a halt. Stall and redirect come from the hazard unit and the ID-stage branch logic.

## Interface
Parameters:
- `IMEM_DEPTH`, 256: instruction memory size in 32-bit words; power of two. `AW = $clog2(IMEM_DEPTH)`.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetch (used only with `IF_HALT_DETECT_EN`).

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: IDLE→RUN request, single-cycle pulse.
- `clear` in 1: HALT→IDLE request, single-cycle pulse.
- `load_we` in 1: instruction memory write strobe, honoured in IDLE only.
- `load_addr` in 32: byte address of the word to write.
- `load_data` in 32: instruction word to write.
- `stall` in 1: hold the PC (load-use hazard).
- `pc_src` in 1: redirect taken (branch or jump resolved in ID).
- `pc_target` in 32: redirect byte address.
- `if_pc` out 32: current PC.
- `if_pc_plus_4` out 32: `if_pc + 4`, modulo 2^32.
- `if_instruction` out 32: fetched word, or 0 (NOP) outside RUN.
- `running` out 1: state == RUN.
- `halted` out 1: state == HALT.
- `fetch_count` out 32: number of PC advances since leaving IDLE.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - HALT.
- IDLE:
  - PC held at 0; `if_instruction` = 0.
  - `load_we` writes `load_data` to `mem[load_addr[AW+1:2]]`; `load_addr[1:0]` and upper bits are ignored.
  - `start` → RUN with PC = 0 and `fetch_count` = 0.
- RUN:
  - `if_instruction = mem[if_pc[AW+1:2]]`, a combinational read. The index wraps and upper PC bits are ignored.
  - `load_we` is ignored.
  - PC update priority:
    1. `stall`: PC held and `fetch_count` held. A simultaneous `pc_src` is discarded, because the hazard unit keeps the branch decision valid until the stall is released.
    2. `pc_src`: PC = `pc_target` with bits [1:0] forced to 0.
    3. Otherwise PC = PC + 4, wrapping 32'hFFFF_FFFC → 0.
  - `fetch_count` increments on each non-stalled update in cases 2 and 3. It wraps at 2^32.
  - `start` is ignored.
- HALT:
  - PC frozen; `if_instruction` = 0; `fetch_count` frozen.
  - `clear` → IDLE with PC = 0. `fetch_count` is held until the next `start`.
  - `start` is ignored.
- Instruction memory has no reset. Contents survive `reset` and `clear`.
- Outputs `if_pc_plus_4` and `if_instruction` are combinational from the PC register and state. The IF/ID register captures them at the clock edge.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE; `if_pc` 0; `if_pc_plus_4` 4; `if_instruction` 0.
  - `running` 0; `halted` 0; `fetch_count` 0.
- Reset asserted mid-RUN: PC becomes 0 and state becomes IDLE immediately. A memory write in flight in the same cycle is not required to complete.
- Memory write latency: a word written at edge N is readable in RUN from N+1 on.
- `start` at edge N: `running`=1 and `if_pc`=0 from N. The first word appears on `if_instruction` in the same cycle.
- Fetch latency is zero cycles: `if_instruction` follows `if_pc` combinationally. A redirect at edge N shows the target instruction after N.
- Halt detection (macro on):
  - Condition: state RUN, `!stall`, `!pc_src`, and `if_instruction == HALT_WORD`.
  - At the next edge: state becomes HALT, PC stays on the halt word's address, and `fetch_count` does not increment.
  - A halt word fetched in a cycle with `pc_src`=1 is on the wrong path and is ignored.
  - A halt word fetched in a cycle with `stall`=1 is re-evaluated the next cycle.
- `start` and `load_we` in the same IDLE cycle: the write completes and RUN begins.

## Configuration
- `IF_HALT_DETECT_EN` defined: HALT_WORD detection is active as described.
- `IF_HALT_DETECT_EN` undefined:
  - No comparator is built. HALT is unreachable and `halted` is tied to 0.
  - HALT_WORD is fetched as an ordinary instruction; RUN continues until `reset`.
  - `clear` is ignored.

## Test plan
- **Reset, load and run:** reset, load words 0..3 with 32'h2001_0005, 32'h2002_0007, 32'h0022_1820, HALT_WORD, then pulse `start`.
  - `if_pc` sequences 0, 4, 8, 12 on consecutive edges, with `if_pc_plus_4` 4, 8, 12, 16.
  - With the macro on, `halted`=1 one edge after PC=12, PC stays 12, `fetch_count`=3, and `if_instruction`=0.
- **Stall:** hold `stall` for 2 cycles at PC=8 → PC remains 8 for 2 cycles, `fetch_count` unchanged, and the instruction is stable. PC=12 on the edge after release.
- **Redirect:** `pc_src`=1 with `pc_target`=32'h0000_0043 at PC=4 → next PC = 32'h40 and `if_instruction` = mem[16]. Asserting `stall` in the same cycle instead → PC stays 4.
- **Wrong-path halt and index wrap:**
  - HALT_WORD at PC=12 with `pc_src`=1 to target 0 → no halt; PC=0.
  - PC = 32'h400 with `IMEM_DEPTH`=256 → reads mem[0].
- **Load gating:** `load_we` during RUN to address 0 with 32'hDEAD_BEEF → mem[0] unchanged, verified after `clear` and `start`.
- **Async reset mid-run:** reset at PC=8 → `if_pc`=0 and `running`=0 before the next clock edge. Memory is retained: a re-`start` refetches the same word at PC 0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program
//   counter and the instruction memory, and presents pc+4 / instruction to the
//   IF/ID pipeline register. An IDLE/RUN/HALT controller lets the debug unit
//   load a program, start execution and observe a halt.
//
//   Optional feature macro: IF_HALT_DETECT_EN
//     defined   : fetching HALT_WORD on the correct path stops fetch (HALT).
//     undefined : no comparator, HALT unreachable, halted tied to 0,
//                 clear ignored.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   start              IDLE->RUN pulse
//   clear              HALT->IDLE pulse
//   load_we/addr/data  instruction memory write port (IDLE only)
//   stall              hold PC (load-use hazard)
//   pc_src/pc_target   redirect from ID-stage branch/jump resolution
//   if_pc              current PC
//   if_pc_plus_4       if_pc + 4 (mod 2^32)
//   if_instruction     fetched word, 0 (NOP) outside RUN
//   running, halted    state flags
//   fetch_count        PC advances since leaving IDLE
// ---------------------------------------------------------------------------
module if_fetch_stage #(
   parameter int          IMEM_DEPTH = 256,
   parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        clear,
   input  logic        load_we,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   input  logic        stall,
   input  logic        pc_src,
   input  logic [31:0] pc_target,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus_4,
   output logic [31:0] if_instruction,
   output logic        running,
   output logic        halted,
   output logic [31:0] fetch_count
);

   localparam int AW = $clog2(IMEM_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_fetch_count;
   logic        r_running;
`ifdef IF_HALT_DETECT_EN
   logic        r_halted;
`endif

   // Instruction memory: no reset, contents survive reset and clear.
   logic [31:0] r_mem [IMEM_DEPTH];

   logic [AW-1:0] w_rd_idx;
   logic [AW-1:0] w_wr_idx;
   logic [31:0]   w_rd_word;
   logic          w_halt_hit;
   logic          w_unused;

   // Word index only; byte offset and bits above the memory size are dropped,
   // so the PC wraps around the memory.
   assign w_rd_idx  = r_pc[AW+1:2];
   assign w_wr_idx  = load_addr[AW+1:2];
   assign w_rd_word = r_mem[w_rd_idx];

`ifdef IF_HALT_DETECT_EN
   // A halt word under a redirect is wrong-path; under a stall it is
   // re-evaluated once the stall releases.
   assign w_halt_hit = (r_state == S_RUN) && !stall && !pc_src &&
                       (w_rd_word == HALT_WORD);
   assign w_unused   = ^{load_addr[31:AW+2], load_addr[1:0], pc_target[1:0]};
`else
   assign w_halt_hit = 1'b0;
   assign w_unused   = ^{load_addr[31:AW+2], load_addr[1:0], pc_target[1:0],
                         clear};
`endif

   // Loader write port, open only while IDLE.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && load_we)
         r_mem[w_wr_idx] <= load_data;
   end

   // Controller and PC/fetch-count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_pc          <= 32'd0;
         r_fetch_count <= 32'd0;
         r_running     <= 1'b0;
`ifdef IF_HALT_DETECT_EN
         r_halted      <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_pc <= 32'd0;
               if (start) begin
                  r_state       <= S_RUN;
                  r_fetch_count <= 32'd0;
                  r_running     <= 1'b1;
               end
            end
            S_RUN: begin
               // Stall wins over a redirect: the hazard unit keeps the branch
               // decision valid until the stall releases.
               if (!stall) begin
                  if (pc_src) begin
                     r_pc          <= {pc_target[31:2], 2'b00};
                     r_fetch_count <= r_fetch_count + 32'd1;
                  end else if (w_halt_hit) begin
                     r_state   <= S_HALT;
                     r_running <= 1'b0;
`ifdef IF_HALT_DETECT_EN
                     r_halted  <= 1'b1;
`endif
                  end else begin
                     r_pc          <= r_pc + 32'd4;
                     r_fetch_count <= r_fetch_count + 32'd1;
                  end
               end
            end
            S_HALT: begin
`ifdef IF_HALT_DETECT_EN
               // fetch_count stays visible until the next start.
               if (clear) begin
                  r_state  <= S_IDLE;
                  r_pc     <= 32'd0;
                  r_halted <= 1'b0;
               end
`else
               r_state   <= S_IDLE;
               r_pc      <= 32'd0;
`endif
            end
            default: begin
               r_state   <= S_IDLE;
               r_pc      <= 32'd0;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign if_pc          = r_pc;
   assign if_pc_plus_4   = r_pc + 32'd4;
   assign if_instruction = (r_state == S_RUN) ? w_rd_word : 32'd0;
   assign running        = r_running;
   assign fetch_count    = r_fetch_count;
`ifdef IF_HALT_DETECT_EN
   assign halted         = r_halted;
`else
   assign halted         = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

   localparam int          DEPTH = 256;
   localparam logic [31:0] HW    = 32'hFFFF_FFFF;
`ifdef IF_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0, clear = 1'b0, load_we = 1'b0;
   logic [31:0] load_addr = '0, load_data = '0;
   logic        stall = 1'b0, pc_src = 1'b0;
   logic [31:0] pc_target = '0;
   logic [31:0] if_pc, if_pc_plus_4, if_instruction, fetch_count;
   logic        running, halted;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 = IDLE, 1 = RUN, 2 = HALT
   logic [31:0] m_mem [DEPTH];
   int          m_st;
   logic [31:0] m_pc, m_fc;

   if_fetch_stage #(.IMEM_DEPTH(DEPTH), .HALT_WORD(HW)) dut (
      .clk(clk), .reset(reset), .start(start), .clear(clear),
      .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
      .stall(stall), .pc_src(pc_src), .pc_target(pc_target),
      .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4),
      .if_instruction(if_instruction), .running(running), .halted(halted),
      .fetch_count(fetch_count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_word(input logic [31:0] a);
      return m_mem[(a / 4) % DEPTH];
   endfunction

   function automatic logic [31:0] m_instr();
      return (m_st == 1) ? m_word(m_pc) : 32'd0;
   endfunction

   // Advance the model by one clock edge from the current input values, let
   // the DUT take the edge, then release every control input.
   task automatic tick();
      case (m_st)
         0: begin
            if (load_we) m_mem[(load_addr / 4) % DEPTH] = load_data;
            if (start) begin m_st = 1; m_pc = 0; m_fc = 0; end
         end
         1: if (!stall) begin
            if (pc_src) begin
               m_pc = pc_target & 32'hFFFF_FFFC; m_fc = m_fc + 1;
            end else if (HALT_EN && m_word(m_pc) == HW) begin
               m_st = 2;
            end else begin
               m_pc = m_pc + 4; m_fc = m_fc + 1;
            end
         end
         default: if (clear) begin m_st = 0; m_pc = 0; end
      endcase
      @(posedge clk); #1;
      start = 0; clear = 0; load_we = 0; stall = 0; pc_src = 0;
   endtask

   task automatic do_reset();
      reset = 1; #2; reset = 0;
      m_st = 0; m_pc = 0; m_fc = 0;
   endtask

   task automatic go();
      start = 1; tick();
   endtask

   task automatic test_reset();
      reset = 1; #2;
      checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp 0", if_pc); end
      checks++; if (if_pc_plus_4 !== 32'd4) begin errors++; $display("FAIL reset_pc4 got %h exp 4", if_pc_plus_4); end
      checks++; if (if_instruction !== 32'd0) begin errors++; $display("FAIL reset_instr got %h exp 0", if_instruction); end
      checks++; if ({running, halted} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {running, halted}); end
      checks++; if (fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fc got %h exp 0", fetch_count); end
      reset = 0;
      m_st = 0; m_pc = 0; m_fc = 0;
   endtask

   task automatic test_load_run();
      logic [31:0] prog [4];
      prog[0] = 32'h2001_0005; prog[1] = 32'h2002_0007;
      prog[2] = 32'h0022_1820; prog[3] = HW;
      for (int i = 0; i < DEPTH; i++) begin
         load_we = 1; load_addr = i * 4 + $urandom_range(0, 3);
         load_data = (i < 4) ? prog[i] : ($urandom & 32'h7FFF_FFFF);
         tick();
      end
      checks++; if (if_instruction !== 32'd0) begin errors++; $display("FAIL idle_instr got %h exp 0", if_instruction); end
      go();
      checks++; if (running !== 1'b1 || if_pc !== 32'd0) begin errors++; $display("FAIL start got run=%b pc=%h exp 1/0", running, if_pc); end
      checks++; if (if_instruction !== prog[0]) begin errors++; $display("FAIL first_word got %h exp %h", if_instruction, prog[0]); end
      for (int i = 1; i < 4; i++) begin
         tick();
         checks++; if (if_pc !== i * 4 || if_pc_plus_4 !== i * 4 + 4) begin
            errors++; $display("FAIL seq_pc got %h/%h exp %h/%h", if_pc, if_pc_plus_4, i * 4, i * 4 + 4);
         end
      end
      tick();
      if (HALT_EN) begin
         checks++; if (halted !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL halt_flags got h=%b r=%b exp 1/0", halted, running); end
         checks++; if (if_pc !== 32'd12 || fetch_count !== 32'd3) begin errors++; $display("FAIL halt_pc_fc got %h/%0d exp c/3", if_pc, fetch_count); end
         checks++; if (if_instruction !== 32'd0) begin errors++; $display("FAIL halt_instr got %h exp 0", if_instruction); end
         start = 1; tick();
         checks++; if (halted !== 1'b1 || if_pc !== 32'd12) begin errors++; $display("FAIL halt_start_ignored got h=%b pc=%h", halted, if_pc); end
         clear = 1; tick();
         checks++; if (halted !== 1'b0 || running !== 1'b0 || if_pc !== 32'd0 || fetch_count !== 32'd3) begin
            errors++; $display("FAIL clear got h=%b r=%b pc=%h fc=%0d exp 0/0/0/3", halted, running, if_pc, fetch_count);
         end
      end else begin
         checks++; if (if_pc !== 32'd16 || fetch_count !== 32'd4 || halted !== 1'b0) begin
            errors++; $display("FAIL nohalt got pc=%h fc=%0d h=%b exp 10/4/0", if_pc, fetch_count, halted);
         end
         do_reset();
      end
   endtask

   task automatic test_stall();
      go(); tick(); tick();
      for (int i = 0; i < 2; i++) begin
         stall = 1; tick();
         checks++; if (if_pc !== 32'd8 || fetch_count !== 32'd2 || if_instruction !== m_mem[2]) begin
            errors++; $display("FAIL stall got pc=%h fc=%0d ins=%h exp 8/2/%h", if_pc, fetch_count, if_instruction, m_mem[2]);
         end
      end
      tick();
      checks++; if (if_pc !== 32'd12) begin errors++; $display("FAIL stall_release got %h exp c", if_pc); end
      do_reset();
   endtask

   task automatic test_redirect();
      go(); tick();
      pc_src = 1; pc_target = 32'h43; tick();
      checks++; if (if_pc !== 32'h40 || if_instruction !== m_mem[16] || fetch_count !== 32'd2) begin
         errors++; $display("FAIL redirect got pc=%h ins=%h fc=%0d exp 40/%h/2", if_pc, if_instruction, fetch_count, m_mem[16]);
      end
      do_reset();
      go(); tick();
      stall = 1; pc_src = 1; pc_target = 32'h43; tick();
      checks++; if (if_pc !== 32'h4 || fetch_count !== 32'd1) begin
         errors++; $display("FAIL stall_over_redirect got pc=%h fc=%0d exp 4/1", if_pc, fetch_count);
      end
      do_reset();
   endtask

   task automatic test_wrong_path_wrap();
      go(); tick(); tick(); tick();
      pc_src = 1; pc_target = 32'h0; tick();
      checks++; if (if_pc !== 32'h0 || halted !== 1'b0 || running !== 1'b1 || fetch_count !== 32'd4) begin
         errors++; $display("FAIL wrong_path got pc=%h h=%b r=%b fc=%0d exp 0/0/1/4", if_pc, halted, running, fetch_count);
      end
      pc_src = 1; pc_target = 32'h400; tick();
      checks++; if (if_pc !== 32'h400 || if_instruction !== 32'h2001_0005) begin
         errors++; $display("FAIL wrap got pc=%h ins=%h exp 400/20010005", if_pc, if_instruction);
      end
      do_reset();
   endtask

   task automatic test_load_gating();
      go();
      load_we = 1; load_addr = 32'h0; load_data = 32'hDEAD_BEEF; tick();
      if (HALT_EN) begin
         tick(); tick(); tick();
         clear = 1; tick();
      end else begin
         do_reset();
      end
      go();
      checks++; if (if_instruction !== 32'h2001_0005) begin
         errors++; $display("FAIL load_gating got %h exp 20010005", if_instruction);
      end
      do_reset();
   endtask

   task automatic test_async_reset();
      go(); tick(); tick();
      reset = 1; #1;
      checks++; if (if_pc !== 32'd0 || running !== 1'b0 || if_instruction !== 32'd0) begin
         errors++; $display("FAIL async_reset got pc=%h r=%b ins=%h exp 0/0/0", if_pc, running, if_instruction);
      end
      reset = 0;
      m_st = 0; m_pc = 0; m_fc = 0;
      go();
      checks++; if (if_instruction !== 32'h2001_0005 || if_pc !== 32'd0) begin
         errors++; $display("FAIL reset_refetch got pc=%h ins=%h", if_pc, if_instruction);
      end
      do_reset();
   endtask

   task automatic test_random();
      int bad = 0;
      go();
      for (int n = 0; n < 600; n++) begin
         if (m_st == 2) clear = ($urandom_range(0, 3) == 0);
         if (m_st == 0) start = ($urandom_range(0, 1) == 0);
         stall = ($urandom_range(0, 3) == 0);
         pc_src = ($urandom_range(0, 4) == 0);
         pc_target = ($urandom_range(0, 1) == 0) ? $urandom : {26'd0, 6'($urandom)};
         if (m_st != 1 || $urandom_range(0, 7) == 0) begin
            load_we = $urandom_range(0, 1);
            load_addr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(4, 1023)) : $urandom;
            load_data = $urandom & 32'h7FFF_FFFF;
         end
         tick();
         checks++;
         if (if_pc !== m_pc || if_pc_plus_4 !== m_pc + 32'd4 || if_instruction !== m_instr() ||
             running !== (m_st == 1) || halted !== (m_st == 2) || fetch_count !== m_fc) begin
            errors++;
            if (bad < 5) $display("FAIL random cyc %0d got pc=%h p4=%h ins=%h r=%b h=%b fc=%0d exp pc=%h ins=%h st=%0d fc=%0d",
                                  n, if_pc, if_pc_plus_4, if_instruction, running, halted, fetch_count,
                                  m_pc, m_instr(), m_st, m_fc);
            bad++;
         end
      end
   endtask

   initial begin
      m_st = 0; m_pc = 0; m_fc = 0;
      #3;
      test_reset();
      test_load_run();
      test_stall();
      test_redirect();
      test_wrong_path_wrap();
      test_load_gating();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
